// File: rtl/queue_tester.sv
// queue_tester: streams an index sequence into a queue and checks it on the way out.
// Optional macro QUEUE_TESTER_STALL_EN adds LFSR-driven dequeue backpressure.
module queue_tester #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] din,
    output logic             enq_val,
    input  logic             enq_rdy,
    input  logic [WIDTH-1:0] dout,
    input  logic             deq_val,
    output logic             deq_rdy,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tx_idx;
    logic [CNT_W-1:0] rx_idx;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] tx_nx;
    logic [CNT_W-1:0] rx_nx;
    logic [7:0]       wdog;

    logic accept;
    logic enq_fire;
    logic deq_fire;
    logic deq_ok;
    logic deq_good;
    logic deq_err;
    logic finish;
    logic expire;
    logic run_nx;
    logic stall_nx;

    assign accept   = start && (state != RUN);
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    // A dequeue ahead of what was sent is bogus data: flag it, keep rx_idx.
    assign deq_ok   = rx_idx < tx_idx;
    assign deq_good = deq_fire && deq_ok;
    assign deq_err  = deq_fire && (!deq_ok || (dout != rx_idx[WIDTH-1:0]));
    assign finish   = (state == RUN) && (rx_idx == cnt_q);
    assign expire   = (state == RUN) && !finish && (wdog == 8'hFF);
    assign run_nx   = (state_nx == RUN);

`ifdef QUEUE_TESTER_STALL_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_nx;

    // x^7 + x^6 + 1, maximal length
    assign lfsr_nx  = (state == RUN) ? {lfsr[5:0], lfsr[6] ^ lfsr[5]} : lfsr;
    assign stall_nx = lfsr_nx[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 7'h5A;
        end else begin
            lfsr <= lfsr_nx;
        end
    end
`else
    assign stall_nx = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (finish || expire) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == '0) && !timeout;
    end

    always_comb begin
        cnt_nx = cnt_q;
        tx_nx  = tx_idx;
        rx_nx  = rx_idx;
        if (accept) begin
            cnt_nx = count;
            tx_nx  = '0;
            rx_nx  = '0;
        end else begin
            if (enq_fire) tx_nx = tx_idx + CNT_W'(1);
            if (deq_good) rx_nx = rx_idx + CNT_W'(1);
        end
    end

    // Handshake outputs are registered from next-cycle state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            tx_idx    <= '0;
            rx_idx    <= '0;
            err_count <= '0;
            timeout   <= 1'b0;
            wdog      <= '0;
            enq_val   <= 1'b0;
            din       <= '0;
            deq_rdy   <= 1'b0;
        end else begin
            cnt_q  <= cnt_nx;
            tx_idx <= tx_nx;
            rx_idx <= rx_nx;
            if (accept) begin
                err_count <= '0;
                timeout   <= 1'b0;
                wdog      <= '0;
            end else begin
                if (deq_err && (err_count != '1)) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (expire) timeout <= 1'b1;
                if (state == RUN) begin
                    wdog <= (enq_fire || deq_fire) ? 8'd0 : wdog + 8'd1;
                end
            end
            enq_val <= run_nx && (tx_nx < cnt_nx);
            din     <= (run_nx && (tx_nx < cnt_nx)) ? tx_nx[WIDTH-1:0] : '0;
            deq_rdy <= run_nx && (rx_nx < cnt_nx) && !stall_nx;
        end
    end

endmodule

// File: tb/tb_queue_tester.sv
// tb_queue_tester: directed runs against a depth-2 queue model with a din scoreboard.
module tb_queue_tester;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] count = 8'd0;
    logic [3:0] din;
    logic       enq_val;
    logic       enq_rdy = 1'b1;
    logic [3:0] dout = 4'd0;
    logic       deq_val = 1'b0;
    logic       deq_rdy;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] fifo[$];
    bit         block_enq = 1'b0;
    int         corrupt_idx = -1;
    int         deq_n = 0;
    logic       m_e;
    logic       m_d;
    logic [3:0] m_din;
    logic [3:0] m_exp;
    int         cyc;

    always #5 clk = ~clk;

    queue_tester #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .din(din), .enq_val(enq_val), .enq_rdy(enq_rdy),
        .dout(dout), .deq_val(deq_val), .deq_rdy(deq_rdy),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Depth-2 queue model; handshakes sampled mid-cycle, state updated after the edge.
    always begin
        @(negedge clk);
        m_e   = (enq_val === 1'b1) && enq_rdy;
        m_d   = (deq_rdy === 1'b1) && deq_val;
        m_din = din;
        if (m_e) begin
            if (exp_q.size() == 0) begin
                check("extra_enq", 32'(m_din), 32'hFFFF);
            end else begin
                m_exp = exp_q.pop_front();
                check("din_seq", 32'(m_din), 32'(m_exp));
            end
        end
        @(posedge clk);
        #1;
        if (m_d) begin
            void'(fifo.pop_front());
            deq_n++;
        end
        if (m_e) fifo.push_back(m_din);
        if (reset) fifo.delete();
        enq_rdy = !block_enq && (fifo.size() < 2);
        deq_val = fifo.size() > 0;
        if (fifo.size() > 0) dout = (deq_n == corrupt_idx) ? 4'd7 : fifo[0];
        else dout = 4'd0;
    end

    task automatic launch(int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(4'(i));
        deq_n = 0;
        count = 8'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("run_bounded", 32'(c < 2000), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_enq_val", 32'(enq_val), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_deq_rdy", 32'(deq_rdy), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        launch(8);
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_enq_val", 32'(enq_val), 32'd0);
        check("mrst_deq_rdy", 32'(deq_rdy), 32'd0);
        check("mrst_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        launch(5);
        wait_done(cyc);
        check("c5_done", 32'(done), 32'd1);
        check("c5_pass", 32'(pass), 32'd1);
        check("c5_err", 32'(err_count), 32'd0);
        check("c5_timeout", 32'(timeout), 32'd0);
        check("c5_all_sent", 32'(exp_q.size()), 32'd0);

        launch(20);
        wait_done(cyc);
        check("c20_pass", 32'(pass), 32'd1);
        check("c20_busy", 32'(busy), 32'd0);
        check("c20_all_sent", 32'(exp_q.size()), 32'd0);

        corrupt_idx = 2;
        launch(4);
        wait_done(cyc);
        check("bad_err", 32'(err_count), 32'd1);
        check("bad_pass", 32'(pass), 32'd0);
        check("bad_done", 32'(done), 32'd1);
        corrupt_idx = -1;

        block_enq = 1'b1;
        @(negedge clk);
        launch(3);
        repeat (5) @(negedge clk);
        check("blk_enq_val", 32'(enq_val), 32'd1);
        check("blk_din", 32'(din), 32'd0);
        repeat (100) @(negedge clk);
        check("blk_din_hold", 32'(din), 32'd0);
        wait_done(cyc);
        check("blk_latency", 32'(cyc), 32'd151);
        check("blk_timeout", 32'(timeout), 32'd1);
        check("blk_pass", 32'(pass), 32'd0);
        check("blk_left", 32'(exp_q.size()), 32'd3);
        block_enq = 1'b0;
        @(negedge clk);
        @(negedge clk);

        launch(0);
        check("z_busy", 32'(busy), 32'd1);
        check("z_enq_val", 32'(enq_val), 32'd0);
        check("z_deq_rdy", 32'(deq_rdy), 32'd0);
        count = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("z_done", 32'(done), 32'd1);
        check("z_pass", 32'(pass), 32'd1);
        check("z_busy_off", 32'(busy), 32'd0);
        @(negedge clk);
        check("z_ignored", 32'(busy), 32'd0);
        check("z_still_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
